prefetch_queue: RTL
===================

Name: prefetch_queue

Overview:
- Parametrised successor to the single-shot fetch stage: a sequential instruction prefetcher with a DEPTH-entry queue.
- Issues word reads to instruction memory through a req/ack handshake and buffers {pc, instr} pairs.
- Presents them to the decoder with a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes the queue and discards any in-flight read; sits between instruction memory and decoder_stage.

Parameters:
- ADDR_W, 16: PC / memory address width.
- INSTR_W, 16: instruction width.
- DEPTH, 4: queue entries; power of two, ≥2.
- PC_STEP, 2: address increment per fetched instruction.
- RESET_PC, 0: fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- mem_req  out  ADDR_W-independent 1  read request, registered.
- mem_addr  out  ADDR_W  read address, registered; stable while mem_req=1 and not acked.
- mem_ack  in  1  read complete; sampled at a clk edge when mem_req=1.
- mem_data  in  INSTR_W  read data, valid in the mem_ack cycle.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_W  new fetch address; bit 0 forced to 0.
- out_valid  out  1  queue head valid.
- out_instr  out  INSTR_W  head instruction.
- out_pc  out  ADDR_W  address of the head instruction.
- out_ready  in  1  decoder accepts the head.
- dbg_count  out  $clog2(DEPTH)+1  current occupancy.
- dbg_state  out  2  FSM state encoding.

Behaviour:
- Reset (asynchronous, active-high):
  - mem_req=0, mem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, count=0.
  - fetch_pc=RESET_PC, state=IDLE.
- FSM states:
  - IDLE=0: no read outstanding.
  - REQ=1: read outstanding, result kept.
  - DISCARD=2: read outstanding, result dropped.
- IDLE:
  - If count<DEPTH and no redirect: mem_req<=1, mem_addr<=fetch_pc, go to REQ.
  - Issue happens one edge after the condition holds, so after reset release the request appears one cycle later.
- REQ, mem_ack=1 without redirect:
  - Push {fetch_pc, mem_data}; fetch_pc += PC_STEP, modulo 2^ADDR_W.
  - If post-edge count (after push and any pop) < DEPTH: mem_req stays 1 with the new address and state stays REQ.
  - Otherwise mem_req<=0 and go to IDLE.
  - With a zero-wait memory (ack in the same cycle as req), throughput is 1 instruction per cycle.
- REQ, mem_ack=0: hold mem_req and mem_addr unchanged.
- Slot reservation:
  - An issue is only made when count<DEPTH. At most one read is outstanding, so an acked read always has a free slot; no overflow is possible.
- Redirect (highest priority, any state):
  - Queue flushed (count<=0, out_valid<=0); any pop in that cycle is ignored.
  - fetch_pc <= {redirect_pc[ADDR_W-1:1], 1'b0}.
  - If a read is outstanding and mem_ack=0: go to DISCARD, keeping mem_req and mem_addr held (the memory protocol requires stability).
  - If mem_ack=1 in the redirect cycle: the data is dropped and a new request to the redirect PC is issued next cycle (state REQ).
  - In IDLE: go to REQ with the redirect PC.
- DISCARD:
  - On mem_ack, drop the data and issue mem_addr=fetch_pc in the next cycle (state REQ).
  - A further redirect while in DISCARD only updates fetch_pc.
- Output side:
  - out_valid = count≠0; head fields registered from the queue storage.
  - Pop when out_valid && out_ready && !redirect.
  - Push and pop in the same cycle leave count unchanged, including when full; the data order is preserved.
  - An entry pushed at edge N is visible at the head (if the queue was empty) with out_valid=1 after edge N.
- Empty/full:
  - out_ready with count=0 has no effect.
  - count never exceeds DEPTH; pointers wrap modulo DEPTH.
- Reset asserted mid-read:
  - All state clears immediately.
  - A late mem_ack while mem_req=0 is ignored.

Decomposition:
- Shared package nqcpu_pkg holds:
  - the fetch FSM state enum (IDLE/REQ/DISCARD);
  - PC_STEP default;
  - a typedef for the {pc, instr} queue entry.
- One sub-module, instr_fifo: a synchronous DEPTH-entry FIFO with push, pop, flush, count, head outputs and asynchronous reset.
- The FSM and PC logic stay in prefetch_queue.

Test Plan:
- Zero-wait memory (mem_ack=mem_req), out_ready=1 → out_pc sequence 0,2,4,6,… one per cycle starting 2 cycles after reset release; mem_data=addr^16'hA5A5 checked per entry.
- out_ready=0, DEPTH=4 → exactly 4 acks accepted, then mem_req=0, dbg_count=4. Raising out_ready gives 4 pops in order (pc 0,2,4,6), then fetching resumes at pc 8.
- Memory with 3-cycle ack latency; redirect to 16'h0101 one cycle after issue → mem_addr held until ack, that data dropped, next mem_addr=16'h0100, first out_pc=16'h0100.
- Redirect coinciding with mem_ack and out_ready while count=2 → count=0 next cycle, no pop counted, next request to redirect_pc.
- fetch_pc=16'hFFFE → next fetch address 16'h0000 (wrap), both entries delivered in order.
- rst asserted while mem_req=1 and the queue is half full → outputs cleared asynchronously before the next edge. An ack arriving after reset does not push, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/nqcpu_pkg.sv
// Shared types for the nqcpu fetch path: fetch FSM encoding, default PC step
// and the {pc, instr} queue entry layout for the default 16-bit configuration.
package nqcpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

  localparam int PC_STEP_DEFAULT = 2;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_queue_if.sv
// Memory read handshake, decoder handshake and redirect bundled for the prefetcher.
interface prefetch_queue_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_data;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               out_ready;

  modport master (
    output mem_req, mem_addr, out_valid, out_instr, out_pc,
    input  mem_ack, mem_data, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_instr, out_pc,
    output mem_ack, mem_data, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fifo.sv
// DEPTH-entry FIFO with flush and a registered head that already shows a
// freshly pushed entry in the cycle right after the push.
module instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] head_reg;
  logic             do_pop, do_push, push_to_head;
  logic [PTR_W-1:0] rd_ptr_inc;

  assign do_pop       = pop && (count_reg != '0);
  assign do_push      = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);
  // The pushed word becomes head when nothing else remains in front of it.
  assign push_to_head = do_push && (count_reg == (do_pop ? CNT_W'(1) : CNT_W'(0)));
  assign rd_ptr_inc   = rd_ptr_reg + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      count_reg <= count_reg + (do_push ? CNT_W'(1) : CNT_W'(0))
                             - (do_pop  ? CNT_W'(1) : CNT_W'(0));
      if (push_to_head) begin
        head_reg <= push_data;
      end else if (do_pop) begin
        head_reg <= mem[rd_ptr_inc];
      end
    end
  end

  assign count = count_reg;
  assign head  = head_reg;
endmodule

// File: rtl/prefetch_queue.sv
// Sequential instruction prefetcher: one outstanding memory read at a time,
// results queued as {pc, instr} for the decoder; redirect flushes and refetches.
module prefetch_queue
  import nqcpu_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = PC_STEP_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  prefetch_queue_if.master       bus,
  output logic [$clog2(DEPTH):0] dbg_count,
  output logic [1:0]             dbg_state
);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  fetch_state_t        state_reg;
  logic [ADDR_W-1:0]   fetch_pc_reg;
  logic                mem_req_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;

  logic [CNT_W-1:0]    count;
  logic [ENTRY_W-1:0]  head;
  logic                out_valid;
  logic                push, pop, flush;
  logic [CNT_W-1:0]    count_next;
  logic [ADDR_W-1:0]   redirect_target, fetch_pc_inc;

  assign out_valid       = (count != '0);
  assign flush           = bus.redirect;
  assign push            = (state_reg == ST_REQ) && bus.mem_ack && !bus.redirect;
  assign pop             = out_valid && bus.out_ready && !bus.redirect;
  assign count_next      = count + (push ? CNT_W'(1) : CNT_W'(0))
                                 - (pop  ? CNT_W'(1) : CNT_W'(0));
  assign redirect_target = {bus.redirect_pc[ADDR_W-1:1], 1'b0};
  assign fetch_pc_inc    = fetch_pc_reg + ADDR_W'(PC_STEP);

  instr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({fetch_pc_reg, bus.mem_data}),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      fetch_pc_reg <= RESET_PC;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= RESET_PC;
    end else if (bus.redirect) begin
      fetch_pc_reg <= redirect_target;
      // An unacked read must stay on the bus; its data is dropped later.
      if (state_reg != ST_IDLE && !bus.mem_ack) begin
        state_reg <= ST_DISCARD;
      end else begin
        state_reg    <= ST_REQ;
        mem_req_reg  <= 1'b1;
        mem_addr_reg <= redirect_target;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (count < CNT_W'(DEPTH)) begin
            state_reg    <= ST_REQ;
            mem_req_reg  <= 1'b1;
            mem_addr_reg <= fetch_pc_reg;
          end
        end
        ST_REQ: begin
          if (bus.mem_ack) begin
            fetch_pc_reg <= fetch_pc_inc;
            if (count_next < CNT_W'(DEPTH)) begin
              mem_addr_reg <= fetch_pc_inc;
            end else begin
              state_reg   <= ST_IDLE;
              mem_req_reg <= 1'b0;
            end
          end
        end
        ST_DISCARD: begin
          if (bus.mem_ack) begin
            state_reg    <= ST_REQ;
            mem_req_reg  <= 1'b1;
            mem_addr_reg <= fetch_pc_reg;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          mem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = head[ENTRY_W-1:INSTR_W];
  assign bus.out_instr = head[INSTR_W-1:0];
  assign dbg_count     = count;
  assign dbg_state     = state_reg;
endmodule
